irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Machine-mode trap sequencer for the RV32 core. Recognises ecall/ebreak/mret in the decode-stage instruction and the external interrupt line. Holds the pipeline while it writes mepc, mstatus and mcause through the CSR write port, then redirects fetch to the trap vector or the return address. Sits beside the decode stage, shares the CSR write port with the execute stage, and drives the pipeline hold/jump controls.

## Interface
- No parameters. Constants come from define.v.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- irq_i  in  1  external interrupt request, level, synchronous to clk
- inst_i  in  32  instruction currently in decode
- inst_addr_i  in  32  address of inst_i
- jump_flag_i  in  1  execute stage is redirecting this cycle
- jump_addr_i  in  32  execute-stage redirect target
- div_busy_i  in  1  multi-cycle divide in flight
- csr_mtvec_i  in  32  current mtvec, direct read
- csr_mepc_i  in  32  current mepc, direct read
- csr_mstatus_i  in  32  current mstatus, direct read
- hold_flag_o  out  1  stall fetch/decode/execute
- we_o  out  1  CSR write enable; has priority over the execute stage on the shared port
- waddr_o  out  32  CSR write address
- data_o  out  32  CSR write data
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  32  redirect target, valid with int_assert_o

## Operation
- Decoded events in IDLE, in priority order:
  - MRET: inst_i == 32'h30200073.
  - ECALL: inst_i == 32'h00000073, cause 11.
  - EBREAK: inst_i == 32'h00100073, cause 3.
  - IRQ: irq_i & mstatus[3] (MIE) & !div_busy_i, cause 32'h8000000B.
- Synchronous events beat IRQ in the same cycle. A lost IRQ stays pending because irq_i is level.
- Captured at trigger:
  - cause.
  - Return address: inst_addr_i for ECALL/EBREAK. For IRQ, jump_addr_i if jump_flag_i, else inst_addr_i.
- FSM states: IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET_ST.
- Trap path: IDLE → MEPC → MSTATUS → MCAUSE → ASSERT → IDLE.
  - MEPC: we_o=1, waddr_o=0x341, data_o=return address.
  - MSTATUS: waddr_o=0x300, data_o = mstatus with bit7 (MPIE) set to old bit3 and bit3 cleared.
  - MCAUSE: waddr_o=0x342, data_o=cause.
  - ASSERT: int_assert_o=1, int_addr_o=csr_mtvec_i.
- MRET path: IDLE → MRET_ST → ASSERT → IDLE.
  - MRET_ST: waddr_o=0x300, data_o = mstatus with bit3 set to old bit7 and bit7 set to 1.
  - ASSERT: int_addr_o=csr_mepc_i.
- Default outputs in every cycle not listed above: we_o=0, int_assert_o=0, waddr_o, data_o and int_addr_o = 0.
- IRQ while div_busy_i=1: no trigger. Re-evaluated every IDLE cycle.
- No nesting: triggers are only accepted in IDLE, and MIE=0 after entry blocks further IRQ.

## Timing
- Reset (rst=0): state=IDLE. All outputs 0. Captured cause and return address 0. Asynchronous entry, synchronous release.
- hold_flag_o is combinational: 1 when a trigger is decoded in IDLE or state≠IDLE. It stays 1 through the ASSERT cycle and drops in the following IDLE cycle.
- we_o, waddr_o, data_o, int_assert_o and int_addr_o are registered. They change only on rising clk.
- Trap latency, with the trigger in cycle N:
  - MEPC write in N+1.
  - MSTATUS in N+2.
  - MCAUSE in N+3.
  - int_assert_o in N+4.
  - A new trigger is accepted from N+5.
- MRET latency: mstatus write in N+1, int_assert_o in N+2.
- The mstatus value used is csr_mstatus_i sampled in the trigger cycle N, so the MEPC write cannot disturb it.
- Reset mid-sequence aborts immediately. CSR writes already issued stand; none are replayed.

## Structure
- define.v gets:
  - CSR addresses `CSR_MEPC`, `CSR_MSTATUS`, `CSR_MCAUSE`.
  - Encodings `INST_ECALL`, `INST_EBREAK`, `INST_MRET`.
  - Cause codes.
  - FSM state encodings (3-bit localparams are acceptable instead).
- Single module, no sub-modules. Implement as one state register plus a registered output block.

## Test plan
1. ECALL: inst_i=32'h00000073 at addr 0x100, mstatus=0x8, mtvec=0x200 → writes (0x341,0x100), (0x300,0x80), (0x342,11), then int_assert_o with 0x200 in N+4. hold_flag_o=1 for N..N+4.
2. IRQ with jump: irq_i=1, MIE=1, jump_flag_i=1, jump_addr_i=0x3C0 → mepc write 0x3C0, mcause 0x8000000B.
3. IRQ masked or deferred: MIE=0, or div_busy_i=1 for 5 cycles → no hold and no we_o. Once div_busy_i falls, the trap starts in the next cycle.
4. MRET: inst_i=32'h30200073, mstatus=0x80, mepc=0x104 → write (0x300,0x88) in N+1, int_assert_o with 0x104 in N+2.
5. Simultaneous ECALL and irq_i=1 → cause 11. After return, with MIE restored, the IRQ is taken.
6. rst low during the MSTATUS cycle → all outputs 0 asynchronously, IDLE after release, no int_assert_o.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants, state encoding and mstatus helpers for the machine-mode trap sequencer.
package irq_ctrl_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEPC    = 3'd1,
    ST_MSTATUS = 3'd2,
    ST_MCAUSE  = 3'd3,
    ST_ASSERT  = 3'd4,
    ST_MRET    = 3'd5
  } state_e;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl.sv
// Machine-mode trap sequencer: decodes ecall/ebreak/mret/irq in decode, writes mepc/mstatus/mcause
// through the shared CSR port while holding the pipeline, then redirects fetch.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_busy_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] ret_addr_q, ret_addr_d;
  logic [31:0] mstatus_q, mstatus_d;

  logic        we_d, int_assert_d;
  logic [31:0] waddr_d, data_d, int_addr_d;

  logic is_mret, is_ecall, is_ebreak, is_irq, in_idle, trigger;

  always_comb begin
    is_mret   = (inst_i == INST_MRET);
    is_ecall  = (inst_i == INST_ECALL);
    is_ebreak = (inst_i == INST_EBREAK);
    is_irq    = irq_i & csr_mstatus_i[MSTATUS_MIE] & ~div_busy_i;
    in_idle   = (state_q == ST_IDLE);
    trigger   = in_idle & (is_mret | is_ecall | is_ebreak | is_irq);
  end

  assign hold_flag_o = ~in_idle | trigger;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    ret_addr_d = ret_addr_q;
    mstatus_d  = mstatus_q;
    unique case (state_q)
      ST_IDLE: begin
        // Synchronous events outrank the interrupt; a lost irq stays pending on the level.
        if (is_mret) begin
          state_d = ST_MRET;
        end else if (is_ecall || is_ebreak) begin
          state_d    = ST_MEPC;
          cause_d    = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          ret_addr_d = inst_addr_i;
          mstatus_d  = csr_mstatus_i;
        end else if (is_irq) begin
          state_d    = ST_MEPC;
          cause_d    = CAUSE_IRQ;
          ret_addr_d = jump_flag_i ? jump_addr_i : inst_addr_i;
          mstatus_d  = csr_mstatus_i;
        end
      end
      ST_MEPC:    state_d = ST_MSTATUS;
      ST_MSTATUS: state_d = ST_MCAUSE;
      ST_MCAUSE:  state_d = ST_ASSERT;
      ST_MRET:    state_d = ST_ASSERT;
      ST_ASSERT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed for the state being entered.
  always_comb begin
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    unique case (state_d)
      ST_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = ret_addr_d;
      end
      ST_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = trap_mstatus(mstatus_q);
      end
      ST_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_q;
      end
      ST_MRET: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mret_mstatus(csr_mstatus_i);
      end
      ST_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = (state_q == ST_MRET) ? csr_mepc_i : csr_mtvec_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cause_q    <= '0;
      ret_addr_q <= '0;
      mstatus_q  <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      ret_addr_q <= ret_addr_d;
      mstatus_q  <= mstatus_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      data_o       <= data_d;
      int_assert_o <= int_assert_d;
      int_addr_o   <= int_addr_d;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected CSR writes/redirects with their cycle,
// a negedge monitor pops and compares whenever the DUT drives we_o or int_assert_o.
module tb_irq_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        irq_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        div_busy_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        hold_flag_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  irq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_i        (irq_i),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .div_busy_i   (div_busy_i),
    .csr_mtvec_i  (csr_mtvec_i),
    .csr_mepc_i   (csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o  (hold_flag_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .data_o       (data_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  typedef struct {
    logic        we;
    logic        ia;
    logic [31:0] waddr;
    logic [31:0] data;
    logic [31:0] iaddr;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the DUT presents a write or redirect, it must match the queue head.
  exp_t e;
  always @(negedge clk) begin
    if (we_o || int_assert_o) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: cycle %0d got we=%b ia=%b waddr=%h data=%h iaddr=%h, required no output",
                 cyc, we_o, int_assert_o, waddr_o, data_o, int_addr_o);
      end else begin
        e = q.pop_front();
        if (we_o !== e.we || int_assert_o !== e.ia || waddr_o !== e.waddr ||
            data_o !== e.data || int_addr_o !== e.iaddr || cyc != e.cyc) begin
          bad++;
          $display("[TB] FAIL sb_output: got cyc=%0d we=%b ia=%b waddr=%h data=%h iaddr=%h, required cyc=%0d we=%b ia=%b waddr=%h data=%h iaddr=%h",
                   cyc, we_o, int_assert_o, waddr_o, data_o, int_addr_o,
                   e.cyc, e.we, e.ia, e.waddr, e.data, e.iaddr);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string name, input logic req);
    #1;
    check_output(name, {31'd0, hold_flag_o}, {31'd0, req});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input int c);
    exp_t x;
    x.we = 1'b1; x.ia = 1'b0; x.waddr = a; x.data = d; x.iaddr = '0; x.cyc = c;
    q.push_back(x);
  endtask

  task automatic push_assert(input logic [31:0] t, input int c);
    exp_t x;
    x.we = 1'b0; x.ia = 1'b1; x.waddr = '0; x.data = '0; x.iaddr = t; x.cyc = c;
    q.push_back(x);
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] ret,
                           input logic [31:0] mst, input logic [31:0] vec);
    push_write(32'h341, ret, cyc + 1);
    push_write(32'h300, mst, cyc + 2);
    push_write(32'h342, cause, cyc + 3);
    push_assert(vec, cyc + 4);
  endtask

  task automatic push_mret(input logic [31:0] mst, input logic [31:0] mepc);
    push_write(32'h300, mst, cyc + 1);
    push_assert(mepc, cyc + 2);
  endtask

  // Cycles after a trigger: pipeline held, decode shows a bubble.
  task automatic apply_tail(input int len, input bit clr_irq, input logic [31:0] new_mst);
    for (int i = 1; i <= len; i++) begin
      tick();
      inst_i      = NOP;
      jump_flag_i = 1'b0;
      if (i == 1) begin
        if (clr_irq) irq_i = 1'b0;
        csr_mstatus_i = new_mst;
      end
      check_hold("hold_busy", 1'b1);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] addr,
                                input logic [31:0] mst);
    tick();
    inst_i        = inst;
    inst_addr_i   = addr;
    csr_mstatus_i = mst;
  endtask

  initial begin
    rst = 1'b0; irq_i = 1'b0; inst_i = NOP; inst_addr_i = '0;
    jump_flag_i = 1'b0; jump_addr_i = '0; div_busy_i = 1'b0;
    csr_mtvec_i = 32'h200; csr_mepc_i = '0; csr_mstatus_i = '0;

    tick(); tick();
    check_output("rst_we", {31'd0, we_o}, 32'd0);
    check_output("rst_ia", {31'd0, int_assert_o}, 32'd0);
    check_output("rst_waddr", waddr_o, 32'd0);
    check_output("rst_data", data_o, 32'd0);
    check_output("rst_iaddr", int_addr_o, 32'd0);
    check_hold("rst_hold", 1'b0);
    rst = 1'b1;
    tick(); tick();

    // ECALL; mstatus changes after the trigger must not affect the mstatus write.
    apply_stimulus(32'h0000_0073, 32'h100, 32'h8);
    check_hold("ecall_hold", 1'b1);
    push_trap(32'd11, 32'h100, 32'h80, 32'h200);
    apply_tail(4, 1'b0, 32'hFFFF_0000);
    apply_stimulus(NOP, 32'h104, 32'h0);
    check_hold("ecall_release", 1'b0);

    // IRQ taken while execute is redirecting.
    apply_stimulus(NOP, 32'h500, 32'h8);
    irq_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h3C0;
    check_hold("irq_jump_hold", 1'b1);
    push_trap(32'h8000_000B, 32'h3C0, 32'h80, 32'h200);
    apply_tail(4, 1'b1, 32'h0);
    apply_stimulus(NOP, 32'h504, 32'h0);
    check_hold("irq_release", 1'b0);

    // EBREAK with MIE=0 and MPP bits set.
    apply_stimulus(32'h0010_0073, 32'h140, 32'h1800);
    check_hold("ebreak_hold", 1'b1);
    push_trap(32'd3, 32'h140, 32'h1800, 32'h200);
    apply_tail(4, 1'b0, 32'h1800);
    apply_stimulus(NOP, 32'h144, 32'h0);
    check_hold("ebreak_release", 1'b0);

    // Masked irq.
    irq_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(NOP, 32'h600, 32'h0);
      check_hold("irq_masked", 1'b0);
    end
    // Deferred by divider, then taken once it falls.
    div_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(NOP, 32'h600, 32'h8);
      check_hold("irq_div_busy", 1'b0);
    end
    apply_stimulus(NOP, 32'h600, 32'h8);
    div_busy_i = 1'b0;
    check_hold("irq_div_done", 1'b1);
    push_trap(32'h8000_000B, 32'h600, 32'h80, 32'h200);
    apply_tail(4, 1'b1, 32'h80);
    apply_stimulus(NOP, 32'h604, 32'h80);
    check_hold("irq2_release", 1'b0);

    // MRET.
    csr_mepc_i = 32'h104;
    apply_stimulus(32'h3020_0073, 32'h700, 32'h80);
    check_hold("mret_hold", 1'b1);
    push_mret(32'h88, 32'h104);
    apply_tail(2, 1'b0, 32'h0);
    apply_stimulus(NOP, 32'h704, 32'h0);
    check_hold("mret_release", 1'b0);

    // ECALL beats a simultaneous irq; the irq is taken after mret restores MIE.
    apply_stimulus(32'h0000_0073, 32'h800, 32'h8);
    irq_i = 1'b1;
    check_hold("ecall_irq_hold", 1'b1);
    push_trap(32'd11, 32'h800, 32'h80, 32'h200);
    apply_tail(4, 1'b0, 32'h80);
    apply_stimulus(NOP, 32'h200, 32'h80);
    check_hold("irq_blocked_in_handler", 1'b0);
    csr_mepc_i = 32'h800;
    apply_stimulus(32'h3020_0073, 32'h204, 32'h80);
    check_hold("mret2_hold", 1'b1);
    push_mret(32'h88, 32'h800);
    apply_tail(2, 1'b0, 32'h88);
    apply_stimulus(NOP, 32'h804, 32'h88);
    check_hold("pending_irq_hold", 1'b1);
    push_trap(32'h8000_000B, 32'h804, 32'h80, 32'h200);
    apply_tail(4, 1'b1, 32'h80);
    apply_stimulus(NOP, 32'h808, 32'h80);
    check_hold("pending_irq_release", 1'b0);

    // Reset in the MSTATUS cycle aborts the sequence.
    apply_stimulus(32'h0000_0073, 32'h180, 32'h8);
    check_hold("abort_hold", 1'b1);
    push_trap(32'd11, 32'h180, 32'h80, 32'h200);
    apply_tail(2, 1'b0, 32'h8);
    rst = 1'b0;
    #1;
    check_output("abort_we", {31'd0, we_o}, 32'd0);
    check_output("abort_waddr", waddr_o, 32'd0);
    check_output("abort_data", data_o, 32'd0);
    check_hold("abort_hold_low", 1'b0);
    @(negedge clk);
    q.delete();
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(NOP, 32'h184, 32'h8);
      check_hold("post_reset_idle", 1'b0);
    end
    check_output("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
